// File: rtl/fib_disp_pkg.sv
// Shared types and segment constants for the Fibonacci result display.
// Segment bytes are {dp,g,f,e,d,c,b,a}, active low.
package fib_disp_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned HELD_W     = DIGIT_W * NUM_DIGITS;
    localparam int unsigned SSEG_W     = 8;

    typedef enum logic [1:0] {
        e_init = 2'd0,
        e_show = 2'd1,
        e_busy = 2'd2
    } t_disp_state;

    localparam logic [SSEG_W-1:0] SSEG_BLANK = 8'hFF;
    localparam logic [SSEG_W-1:0] SSEG_DASH  = 8'hBF;
    localparam logic [SSEG_W-1:0] SSEG_ERR   = 8'h86;

    // Patterns for decimal digits 0..9 with the decimal point off
    localparam logic [SSEG_W-1:0] DIGIT_SSEG [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

endpackage

// File: rtl/fib_disp_bcd_to_sseg.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes show "E".
module bcd_to_sseg
    import fib_disp_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               dp,
    output logic [SSEG_W-1:0]  sseg_c
);

    always_comb begin
        sseg_c = SSEG_ERR;
        if (digit <= 4'd9) begin
            sseg_c = DIGIT_SSEG[digit];
        end
        sseg_c[SSEG_W-1] = ~dp;
    end

endmodule

// File: rtl/fib_disp.sv
// Display back end: holds the last BCD result and scans it onto a
// four-digit multiplexed seven-segment display with busy blink and dot.
module fib_disp
    import fib_disp_pkg::*;
#(
    parameter int unsigned REFRESH_BITS = 18,
    parameter int unsigned BLINK_BITS   = 25
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ready,
    input  logic        i_done,
    input  logic [3:0]  i_bcd3,
    input  logic [3:0]  i_bcd2,
    input  logic [3:0]  i_bcd1,
    input  logic [3:0]  i_bcd0,
    output logic [3:0]  o_an,
    output logic [7:0]  o_sseg
);

    t_disp_state             state;
    t_disp_state             state_nxt_c;
    logic                    latch_c;
    logic [HELD_W-1:0]       held;
    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [BLINK_BITS-1:0]   blink_cnt;

    logic [1:0]              digit_idx_c;
    logic [DIGIT_W-1:0]      digit_c;
    logic [NUM_DIGITS-1:0]   lead_blank_c;
    logic                    dp_c;
    logic                    blink_off_c;
    logic [SSEG_W-1:0]       dec_c;
    logic [3:0]              an_c;
    logic [SSEG_W-1:0]       sseg_c;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= e_init;
        end else begin
            state <= state_nxt_c;
        end
    end

    // Next state; a done pulse always wins over ready dropping
    always_comb begin
        state_nxt_c = state;
        latch_c     = 1'b0;
        case (state)
            e_init: begin
                if (i_done) begin
                    latch_c     = 1'b1;
                    state_nxt_c = e_show;
                end
            end
            e_show: begin
                if (i_done) begin
                    latch_c     = 1'b1;
                    state_nxt_c = e_show;
                end else if (!i_ready) begin
                    state_nxt_c = e_busy;
                end
            end
            e_busy: begin
                if (i_done) begin
                    latch_c     = 1'b1;
                    state_nxt_c = e_show;
                end
            end
            default: begin
                state_nxt_c = e_init;
            end
        endcase
    end

    // Held result, digit 3 in the top nibble
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            held <= '0;
        end else if (latch_c) begin
            held <= {i_bcd3, i_bcd2, i_bcd1, i_bcd0};
        end
    end

    // Refresh scan counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
        end
    end

    // Blink counter restarts on busy entry so each busy period opens visible
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            blink_cnt <= '0;
        end else if (state_nxt_c == e_busy && state != e_busy) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + BLINK_BITS'(1);
        end
    end

    assign digit_idx_c = refresh_cnt[REFRESH_BITS-1 -: 2];
    assign blink_off_c = blink_cnt[BLINK_BITS-1];
    assign dp_c        = (state == e_busy) && (digit_idx_c == 2'd0);

    // Digit mux and leading-zero suppression
    always_comb begin
        digit_c = held[3:0];
        case (digit_idx_c)
            2'd0:    digit_c = held[3:0];
            2'd1:    digit_c = held[7:4];
            2'd2:    digit_c = held[11:8];
            2'd3:    digit_c = held[15:12];
            default: digit_c = held[3:0];
        endcase
        lead_blank_c    = '0;
        lead_blank_c[3] = (held[15:12] == 4'd0);
        lead_blank_c[2] = lead_blank_c[3] && (held[11:8] == 4'd0);
        lead_blank_c[1] = lead_blank_c[2] && (held[7:4] == 4'd0);
    end

    bcd_to_sseg u_bcd_to_sseg (
        .digit  (digit_c),
        .dp     (dp_c),
        .sseg_c (dec_c)
    );

    // Next anode/segment values, registered below
    always_comb begin
        an_c              = 4'b1111;
        an_c[digit_idx_c] = 1'b0;
        sseg_c            = SSEG_BLANK;
        case (state)
            e_init: begin
                sseg_c = SSEG_DASH;
            end
            e_show: begin
                if (!lead_blank_c[digit_idx_c]) begin
                    sseg_c = dec_c;
                end
            end
            e_busy: begin
                if (!blink_off_c && !lead_blank_c[digit_idx_c]) begin
                    sseg_c = dec_c;
                end
            end
            default: begin
                sseg_c = SSEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_an   <= 4'b1111;
            o_sseg <= SSEG_BLANK;
        end else begin
            o_an   <= an_c;
            o_sseg <= sseg_c;
        end
    end

endmodule

// File: tb/tb_fib_disp.sv
// Directed bench for fib_disp with short refresh and blink counters.
module tb_fib_disp;

    logic       clk = 1'b0;
    logic       rst;
    logic       ready;
    logic       done;
    logic [3:0] b3, b2, b1, b0;
    logic [3:0] an;
    logic [7:0] sseg;

    int checks = 0;
    int errors = 0;

    // Reference refresh counter: output lags it by one cycle
    logic [3:0] mcnt;

    always #5 clk = ~clk;

    always @(posedge clk) mcnt <= rst ? 4'd0 : mcnt + 4'd1;

    fib_disp #(
        .REFRESH_BITS (4),
        .BLINK_BITS   (6)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_ready (ready),
        .i_done  (done),
        .i_bcd3  (b3),
        .i_bcd2  (b2),
        .i_bcd1  (b1),
        .i_bcd0  (b0),
        .o_an    (an),
        .o_sseg  (sseg)
    );

    function automatic logic [1:0] exp_k();
        logic [3:0] p;
        p = mcnt - 4'd1;
        return p[3:2];
    endfunction

    function automatic logic [3:0] an_of(input logic [1:0] k);
        logic [3:0] a;
        a = 4'b1111;
        a[k] = 1'b0;
        return a;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_done(input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0);
        b3 = d3; b2 = d2; b1 = d1; b0 = d0;
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] k;
        rst = 1'b1; ready = 1'b1; done = 1'b0;
        b3 = 4'd0; b2 = 4'd0; b1 = 4'd0; b0 = 4'd0;
        step();
        step();
        checks++;
        if (an !== 4'b1111 || sseg !== 8'hFF) begin
            errors++;
            $display("FAIL reset an=%b sseg=%h expected an=1111 sseg=ff", an, sseg);
        end
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            k = exp_k();
            checks++;
            if (an !== an_of(k) || sseg !== 8'hBF) begin
                errors++;
                $display("FAIL dash_scan cyc=%0d an=%b sseg=%h expected an=%b sseg=bf",
                         i, an, sseg, an_of(k));
            end
        end
    endtask

    task automatic test_init_ready_low();
        ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (an !== an_of(exp_k()) || sseg !== 8'hBF) begin
                errors++;
                $display("FAIL init_ready_low cyc=%0d an=%b sseg=%h expected an=%b sseg=bf",
                         i, an, sseg, an_of(exp_k()));
            end
        end
        ready = 1'b1;
        step();
    endtask

    task automatic test_show_0055();
        logic [7:0] exp [4] = '{8'h92, 8'h92, 8'hFF, 8'hFF};
        logic [1:0] k;
        do_done(4'd0, 4'd0, 4'd5, 4'd5);
        step();
        for (int i = 0; i < 16; i++) begin
            k = exp_k();
            checks++;
            if (an !== an_of(k) || sseg !== exp[k]) begin
                errors++;
                $display("FAIL show_0055 k=%0d an=%b sseg=%h expected an=%b sseg=%h",
                         k, an, sseg, an_of(k), exp[k]);
            end
            step();
        end
    endtask

    task automatic test_zero_and_nines();
        logic [7:0] exp_z [4] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
        logic [1:0] k;
        do_done(4'd0, 4'd0, 4'd0, 4'd0);
        step();
        for (int i = 0; i < 16; i++) begin
            k = exp_k();
            checks++;
            if (an !== an_of(k) || sseg !== exp_z[k]) begin
                errors++;
                $display("FAIL show_0000 k=%0d an=%b sseg=%h expected an=%b sseg=%h",
                         k, an, sseg, an_of(k), exp_z[k]);
            end
            step();
        end
        do_done(4'd9, 4'd9, 4'd9, 4'd9);
        step();
        for (int i = 0; i < 16; i++) begin
            k = exp_k();
            checks++;
            if (an !== an_of(k) || sseg !== 8'h90) begin
                errors++;
                $display("FAIL show_9999 k=%0d an=%b sseg=%h expected an=%b sseg=90",
                         k, an, sseg, an_of(k));
            end
            step();
        end
    endtask

    task automatic test_busy_blink();
        logic [7:0] exp_b [4] = '{8'h19, 8'h99, 8'hF9, 8'hFF};
        logic [7:0] exp_s [4] = '{8'hB0, 8'hB0, 8'hA4, 8'hFF};
        logic [7:0] e;
        logic [1:0] k;
        do_done(4'd0, 4'd1, 4'd4, 4'd4);
        step();
        step();
        ready = 1'b0;
        step();
        // After entry edge E, the output at E+j reflects blink count j-1
        for (int j = 1; j <= 64; j++) begin
            step();
            k = exp_k();
            e = (j - 1 >= 32) ? 8'hFF : exp_b[k];
            checks++;
            if (an !== an_of(k) || sseg !== e) begin
                errors++;
                $display("FAIL busy_blink j=%0d k=%0d an=%b sseg=%h expected an=%b sseg=%h",
                         j, k, an, sseg, an_of(k), e);
            end
        end
        ready = 1'b1;
        do_done(4'd0, 4'd2, 4'd3, 4'd3);
        step();
        for (int i = 0; i < 48; i++) begin
            k = exp_k();
            checks++;
            if (an !== an_of(k) || sseg !== exp_s[k]) begin
                errors++;
                $display("FAIL busy_exit k=%0d an=%b sseg=%h expected an=%b sseg=%h",
                         k, an, sseg, an_of(k), exp_s[k]);
            end
            step();
        end
    endtask

    task automatic test_done_with_ready_fall();
        logic [7:0] exp [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        logic [1:0] k;
        ready = 1'b0;
        do_done(4'd1, 4'd2, 4'd3, 4'd4);
        ready = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            k = exp_k();
            checks++;
            if (an !== an_of(k) || sseg !== exp[k]) begin
                errors++;
                $display("FAIL done_wins k=%0d an=%b sseg=%h expected an=%b sseg=%h",
                         k, an, sseg, an_of(k), exp[k]);
            end
            step();
        end
    endtask

    task automatic test_reset_in_busy();
        logic [7:0] exp [4] = '{8'h86, 8'hFF, 8'hFF, 8'hFF};
        logic [1:0] k;
        ready = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        ready = 1'b1;
        step();
        checks++;
        if (an !== 4'b1111 || sseg !== 8'hFF) begin
            errors++;
            $display("FAIL reset_busy an=%b sseg=%h expected an=1111 sseg=ff", an, sseg);
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            k = exp_k();
            checks++;
            if (an !== an_of(k) || sseg !== 8'hBF) begin
                errors++;
                $display("FAIL reset_dash k=%0d an=%b sseg=%h expected an=%b sseg=bf",
                         k, an, sseg, an_of(k));
            end
        end
        do_done(4'd0, 4'd0, 4'd0, 4'hA);
        step();
        for (int i = 0; i < 16; i++) begin
            k = exp_k();
            checks++;
            if (an !== an_of(k) || sseg !== exp[k]) begin
                errors++;
                $display("FAIL non_bcd k=%0d an=%b sseg=%h expected an=%b sseg=%h",
                         k, an, sseg, an_of(k), exp[k]);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_init_ready_low();
        test_show_0055();
        test_zero_and_nines();
        test_busy_blink();
        test_done_with_ready_fall();
        test_reset_in_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fib_disp.md
Name: fib_disp

Overview:
- Display back end for the Fibonacci generator. It sits directly downstream of the Fibonacci control block.
- Captures the 4-digit BCD result on the control block's done pulse and drives a time-multiplexed, active-low 4-digit seven-segment display.
- Blanks leading zeros.
- Shows dashes before the first result. While a computation is in flight it blinks the held value and lights a busy dot.

Parameters:
- REFRESH_BITS, 18, refresh counter width; the top 2 bits select the digit being driven.
- BLINK_BITS, 25, blink counter width; the MSB is the blink phase (1 = segments blanked).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_ready  in  1  control block idle/ready level
- i_done  in  1  one-cycle result-valid pulse from the control block
- i_bcd3, i_bcd2, i_bcd1, i_bcd0  in  4 each  result digits (bcd3 = most significant); sampled only when i_done is high
- o_an  out  4  digit anodes, active low, one-hot low; o_an[k] drives digit k
- o_sseg  out  8  segments {dp,g,f,e,d,c,b,a}, active low

Behaviour:
- Interface: one clock (i_clk). Reset i_rst is synchronous and active-high.
- Reset values:
  - state = e_init, held digits = 0, both counters = 0.
  - o_an = 4'b1111, o_sseg = 8'hFF; these are the values on the first edge after reset is asserted.
  - Reset mid-operation discards the held value and returns to dashes.
- Refresh counter:
  - Free-running, wraps at 2^REFRESH_BITS.
  - Digit index k = cnt[MSB:MSB-1], scanned in the order 0,1,2,3,0,...
- Blink counter:
  - Free-running; cleared on every entry to e_busy so each busy period starts with the digits visible.
- Outputs: o_an and o_sseg are registered, so they lag the counter/state by exactly 1 cycle.
- States:
  - e_init: all digits show a dash (8'hBF). i_done -> latch the digits, go to e_show. i_ready low alone -> stay in e_init (dashes persist).
  - e_show: show the held value. i_ready falling (low while in e_show) -> e_busy.
  - e_busy: show the held value. Segments are forced to 8'hFF while the blink MSB is 1. The dp of digit 0 is lit (o_sseg[7] = 0) whenever the digit is not blink-blanked. i_done -> latch the digits, go to e_show.
- Simultaneous events:
  - i_done with i_ready low in the same cycle: i_done wins. Latch and go to e_show.
  - i_done in e_show: re-latch and stay in e_show.
- Leading-zero blanking (held digits h3..h0; blank = 8'hFF):
  - Digit 3 blanks if h3 = 0.
  - Digit 2 blanks if h3 = h2 = 0.
  - Digit 1 blanks if h3 = h2 = h1 = 0.
  - Digit 0 never blanks, so a value of 0 shows as a single "0".
- Encoding (active low, dp off):
  - 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99, 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90.
  - Non-BCD A–F displays "E" (86).
- Width rules: the held register is 16 bits. No arithmetic on digits; the counters wrap silently.

Decomposition:
- Package fib_disp_pkg contains:
  - the t_disp_state enum {e_init, e_show, e_busy};
  - segment constants SSEG_BLANK, SSEG_DASH, SSEG_ERR;
  - a 10-entry digit-pattern constant array.
- Sub-module bcd_to_sseg: combinational, 4-bit digit + dp in -> 8-bit active-low pattern, A–F -> SSEG_ERR. One instance fed by the digit mux.

Test Plan (REFRESH_BITS = 4, BLINK_BITS = 6):
- Reset, then run 64 cycles with no i_done -> o_an cycles 1110, 1101, 1011, 0111, each held 4 cycles; o_sseg = BF on every digit.
- i_done with digits 0,0,5,5 -> from the next refresh, digit 0 = 92 and digit 1 = 92; digits 2 and 3 = FF.
- i_done with 0,0,0,0 -> digit 0 = C0, the others FF. Then i_done with 9,9,9,9 -> all digits 90.
- From e_show (held 0,1,4,4), drop i_ready -> blink MSB = 0: digit 0 = 19 (4 + dp), digit 1 = 99, digit 2 = F9, digit 3 = FF. Blink MSB = 1 (cycles 32–63 after entry): all digits FF. A later i_done with 0,2,3,3 -> digit 2 = A4, digit 1 = B0, no dp, no blink.
- i_done with digits 1,2,3,4 asserted in the same cycle i_ready falls -> state e_show, digit 3 = F9, no blinking.
- Assert i_rst while in e_busy -> next edge o_an = 1111, o_sseg = FF; after release, dashes appear. Digit A on i_bcd0 -> digit 0 shows 86.
